// File: rtl/m_store_buf_pkg.sv
// Shared store-path definitions: operation codes common with the load extender,
// and the layout of one store-buffer entry.
package m_store_buf_pkg;

    localparam logic [4:0] OP_W = 5'd0;
    localparam logic [4:0] OP_H = 5'd1;
    localparam logic [4:0] OP_B = 5'd2;

    typedef struct packed {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_entry_t;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/m_store_buf_if.sv
// Store request port (pipeline -> buffer) and memory write port (buffer -> memory),
// both valid/ready handshakes.
interface m_store_req_if;
    logic        st_valid;
    logic        st_ready;
    logic [4:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    modport master (output st_valid, st_op, st_addr, st_data, input st_ready);
    modport slave  (input st_valid, st_op, st_addr, st_data, output st_ready);
endinterface

interface m_store_mem_if;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;

    modport master (output mem_wvalid, mem_waddr, mem_wdata, mem_wbe, input mem_wready);
    modport slave  (input mem_wvalid, mem_waddr, mem_wdata, mem_wbe, output mem_wready);
endinterface

// File: rtl/m_store_buf_be_gen.sv
// Byte-enable and lane-replicated write data generation for sw/sh/sb,
// plus alignment and op-code validity.
import m_store_buf_pkg::*;

module m_be_gen (
    input  logic [4:0]  st_op,
    input  logic [1:0]  addr,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        aligned,
    output logic        op_ok
);

    always_comb begin
        be      = 4'b0000;
        wdata   = 32'h0;
        aligned = 1'b0;
        op_ok   = 1'b1;
        case (st_op)
            OP_W: begin
                be      = 4'b1111;
                wdata   = st_data;
                aligned = (addr == 2'b00);
            end
            OP_H: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{st_data[15:0]}};
                aligned = ~addr[0];
            end
            OP_B: begin
                be      = 4'b0001 << addr;
                wdata   = {4{st_data[7:0]}};
                aligned = 1'b1;
            end
            default: op_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/m_store_buf.sv
// M-stage store buffer: encodes stores, queues them in order and drains them
// to data memory; flags misaligned stores.
import m_store_buf_pkg::*;

module m_store_buf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    m_store_req_if.slave     req,
    m_store_mem_if.master    mem,
    output logic             misalign_exc,
    output logic             buf_empty,
    output logic [CNT_W-1:0] buf_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    st_entry_t        entries [DEPTH];
    st_entry_t        head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aligned;
    logic        op_ok;
    logic        attempt;
    logic        push;
    logic        pop;

    m_be_gen u_be_gen (
        .st_op   (req.st_op),
        .addr    (req.st_addr[1:0]),
        .st_data (req.st_data),
        .be      (be),
        .wdata   (wdata),
        .aligned (aligned),
        .op_ok   (op_ok)
    );

    // Ready depends only on count, so a same-cycle pop never opens a full buffer.
    assign req.st_ready = (count != FULL);
    assign attempt      = req.st_valid & req.st_ready & op_ok;
    assign push         = attempt & aligned;
    assign pop          = mem.mem_wvalid & mem.mem_wready;

    assign head           = entries[rd_ptr];
    assign mem.mem_wvalid = (count != '0);
    assign mem.mem_waddr  = head.waddr;
    assign mem.mem_wdata  = head.wdata;
    assign mem.mem_wbe    = head.be;
    assign buf_empty      = (count == '0);
    assign buf_count      = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            misalign_exc <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            misalign_exc <= attempt & ~aligned;
            if (push) begin
                entries[wr_ptr] <= '{waddr: word_addr(req.st_addr), wdata: wdata, be: be};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_m_store_buf.sv
// Directed self-checking bench for the M-stage store buffer.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_m_store_buf;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       misalign_exc;
    logic       buf_empty;
    logic [1:0] buf_count;

    int compared = 0;
    int mismatched = 0;

    m_store_req_if req ();
    m_store_mem_if mem ();

    m_store_buf #(.DEPTH(2), .CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mem          (mem),
        .misalign_exc (misalign_exc),
        .buf_empty    (buf_empty),
        .buf_count    (buf_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] d);
        req.st_valid = v;
        req.st_op    = op;
        req.st_addr  = a;
        req.st_data  = d;
    endtask

    task automatic test_reset();
        logic [71:0] got;
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        mem.mem_wready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        got = {mem.mem_wvalid, mem.mem_waddr, mem.mem_wbe, mem.mem_wdata,
               buf_empty, req.st_ready, buf_count, misalign_exc};
        compared++;
        if (got !== {1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected %h", got,
                     {1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b0});
        end
        step();
    endtask

    task automatic test_word();
        logic [68:0] got;
        mem.mem_wready = 1'b1;
        drive(1'b1, 5'd0, 32'h100, 32'h12345678);
        step();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        got = {mem.mem_wvalid, mem.mem_waddr, mem.mem_wbe, mem.mem_wdata};
        compared++;
        if (got !== {1'b1, 32'h100, 4'b1111, 32'h12345678}) begin
            mismatched++;
            $display("FAIL sw_head: got %h expected %h", got,
                     {1'b1, 32'h100, 4'b1111, 32'h12345678});
        end
        step();
        compared++;
        if (buf_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL sw_drained: got %b expected 1", buf_empty);
        end
    endtask

    task automatic test_half_byte();
        logic [68:0] got;
        mem.mem_wready = 1'b1;
        drive(1'b1, 5'd1, 32'h102, 32'hAAAABEEF);
        step();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        got = {mem.mem_wvalid, mem.mem_waddr, mem.mem_wbe, mem.mem_wdata};
        compared++;
        if (got !== {1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF}) begin
            mismatched++;
            $display("FAIL sh_head: got %h expected %h", got,
                     {1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF});
        end
        step();
        drive(1'b1, 5'd2, 32'h203, 32'h000000C3);
        step();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        got = {mem.mem_wvalid, mem.mem_waddr, mem.mem_wbe, mem.mem_wdata};
        compared++;
        if (got !== {1'b1, 32'h200, 4'b1000, 32'hC3C3C3C3}) begin
            mismatched++;
            $display("FAIL sb_head: got %h expected %h", got,
                     {1'b1, 32'h200, 4'b1000, 32'hC3C3C3C3});
        end
        step();
        compared++;
        if (buf_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL sb_drained: got %b expected 1", buf_empty);
        end
    endtask

    task automatic test_full_stall();
        logic [35:0] got;
        mem.mem_wready = 1'b0;
        drive(1'b1, 5'd0, 32'h300, 32'h11111111);
        step();
        drive(1'b1, 5'd0, 32'h304, 32'h22222222);
        step();
        drive(1'b1, 5'd0, 32'h308, 32'h33333333);
        step();
        got = {req.st_ready, buf_count, misalign_exc, mem.mem_waddr};
        compared++;
        if (got !== {1'b0, 2'd2, 1'b0, 32'h300}) begin
            mismatched++;
            $display("FAIL full_stall: got %h expected %h", got,
                     {1'b0, 2'd2, 1'b0, 32'h300});
        end
        step();
        compared++;
        if ({mem.mem_waddr, mem.mem_wdata} !== {32'h300, 32'h11111111}) begin
            mismatched++;
            $display("FAIL head_stable: got %h expected %h",
                     {mem.mem_waddr, mem.mem_wdata}, {32'h300, 32'h11111111});
        end
        mem.mem_wready = 1'b1;
        #1;
        compared++;
        if (req.st_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_no_comb: got %b expected 0", req.st_ready);
        end
        step();
        got = {req.st_ready, buf_count, misalign_exc, mem.mem_waddr};
        compared++;
        if (got !== {1'b1, 2'd1, 1'b0, 32'h304}) begin
            mismatched++;
            $display("FAIL first_pop: got %h expected %h", got,
                     {1'b1, 2'd1, 1'b0, 32'h304});
        end
        step();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        got = {req.st_ready, buf_count, misalign_exc, mem.mem_waddr};
        compared++;
        if (got !== {1'b1, 2'd1, 1'b0, 32'h308} || mem.mem_wdata !== 32'h33333333) begin
            mismatched++;
            $display("FAIL drain_order: got %h/%h expected %h/33333333", got,
                     mem.mem_wdata, {1'b1, 2'd1, 1'b0, 32'h308});
        end
        step();
        compared++;
        if (buf_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL full_drained: got %b expected 1", buf_empty);
        end
    endtask

    task automatic test_misalign();
        logic [4:0]  ops [3] = '{5'd0, 5'd1, 5'd5};
        logic [31:0] adr [3] = '{32'h101, 32'h103, 32'h100};
        logic        exc [3] = '{1'b1, 1'b1, 1'b0};
        mem.mem_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], adr[i], 32'hDEADBEEF);
            step();
            drive(1'b0, 5'd0, 32'h0, 32'h0);
            compared++;
            if ({misalign_exc, buf_count} !== {exc[i], 2'd0}) begin
                mismatched++;
                $display("FAIL misalign_%0d: got %b expected %b", i,
                         {misalign_exc, buf_count}, {exc[i], 2'd0});
            end
            step();
            compared++;
            if ({misalign_exc, buf_count} !== 3'b000) begin
                mismatched++;
                $display("FAIL misalign_pulse_%0d: got %b expected 000", i,
                         {misalign_exc, buf_count});
            end
        end
    endtask

    task automatic test_push_pop();
        mem.mem_wready = 1'b0;
        drive(1'b1, 5'd0, 32'h400, 32'h44444444);
        step();
        mem.mem_wready = 1'b1;
        drive(1'b1, 5'd2, 32'h405, 32'h000000A5);
        step();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        compared++;
        if ({buf_count, mem.mem_waddr, mem.mem_wbe, mem.mem_wdata} !==
            {2'd1, 32'h404, 4'b0010, 32'hA5A5A5A5}) begin
            mismatched++;
            $display("FAIL push_pop: got %h expected %h",
                     {buf_count, mem.mem_waddr, mem.mem_wbe, mem.mem_wdata},
                     {2'd1, 32'h404, 4'b0010, 32'hA5A5A5A5});
        end
        step();
        compared++;
        if (buf_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL push_pop_drain: got %b expected 1", buf_empty);
        end
    endtask

    task automatic test_async_reset();
        logic [71:0] got;
        mem.mem_wready = 1'b0;
        drive(1'b1, 5'd0, 32'h500, 32'h55555555);
        step();
        drive(1'b1, 5'd0, 32'h504, 32'h66666666);
        step();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        got = {mem.mem_wvalid, mem.mem_waddr, mem.mem_wbe, mem.mem_wdata,
               buf_empty, req.st_ready, buf_count, misalign_exc};
        compared++;
        if (got !== {1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset: got %h expected %h", got,
                     {1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b0});
        end
        step();
        reset = 1'b0;
        mem.mem_wready = 1'b1;
        drive(1'b1, 5'd0, 32'h600, 32'h77777777);
        step();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        compared++;
        if ({buf_count, mem.mem_waddr, mem.mem_wdata} !== {2'd1, 32'h600, 32'h77777777}) begin
            mismatched++;
            $display("FAIL post_reset_push: got %h expected %h",
                     {buf_count, mem.mem_waddr, mem.mem_wdata},
                     {2'd1, 32'h600, 32'h77777777});
        end
        step();
        compared++;
        if (buf_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL post_reset_drain: got %b expected 1", buf_empty);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_half_byte();
        test_full_stall();
        test_misalign();
        test_push_pop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
